// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that processes DIGIT bits per
// clock through one DIGIT-wide full-adder slice and a carry register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request strobe; accepted only when busy=0
//   a, b   WIDTH-bit operands, latched on an accepted start
//   cin    carry-in (sub=0) or borrow-in (sub=1), latched on start
//   sub    0: a+b+cin, 1: a-b-cin, latched on start
//   busy   high while an operation is in progress (STEPS cycles)
//   done   one-cycle pulse when s/cout/ovf are updated
//   s      result modulo 2^WIDTH
//   cout   carry-out (sub=0) or NOT borrow-out (sub=1)
//   ovf    two's-complement signed overflow
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned DW    = DIGIT + 1;

  // Reject parameter sets the digit-serial datapath cannot represent.
  if (WIDTH == 0 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "serial_adder: WIDTH must be a nonzero integer multiple of DIGIT");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice_full;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] res_nxt;
  logic             last_step;

  // DIGIT-wide full-adder slice on the low digit of the operand registers.
  always_comb begin
    slice_full = DW'(a_reg[DIGIT-1:0]) + DW'(b_reg[DIGIT-1:0]) + DW'(carry);
    slice_sum  = slice_full[DIGIT-1:0];
    slice_cout = slice_full[DIGIT];
    // Carry into the slice MSB, recovered from the sum bit; on the last
    // step this is the carry into the result MSB.
    msb_cin    = slice_sum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
    // New digit enters at the top; LSB digit ends up at the bottom after STEPS shifts.
    res_nxt    = WIDTH'({slice_sum, res_sr} >> DIGIT);
    last_step  = (cnt == CW'(STEPS - 1));
  end

  // Control, operand shifting and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            // Subtraction as a + ~b + ~cin.
            b_reg <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg  <= a_reg >> DIGIT;
          b_reg  <= b_reg >> DIGIT;
          res_sr <= res_nxt;
          carry  <= slice_cout;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            s     <= res_nxt;
            cout  <= slice_cout;
            ovf   <= msb_cin ^ slice_cout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full adder. It latches two WIDTH-bit operands on a start strobe. It then adds DIGIT bits per clock through an internal full-adder slice and a carry register. The result, carry-out and signed-overflow flag are presented with a one-cycle done pulse. It serves datapaths that trade latency for area: one DIGIT-wide adder slice replaces a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 1.
DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration-time check, fatal on violation).

Ports:
Clk  input  1  rising-edge clock.
Rst_n  input  1  asynchronous active-low reset.
Start  input  1  request; sampled on rising Clk; accepted only when Busy=0.
A  input  WIDTH  operand A; latched on an accepted Start.
B  input  WIDTH  operand B; latched on an accepted Start.
Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1); latched on an accepted Start.
Sub  input  1  mode: 0 = A+B+Cin, 1 = A-B-Cin; latched on an accepted Start.
Busy  output  1  high while an operation is in progress.
Done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
S  output  WIDTH  result, modulo 2^WIDTH.
Cout  output  1  carry-out (Sub=0) or NOT borrow-out (Sub=1).
Ovf  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Async reset (Rst_n=0): state=IDLE; Busy=0, Done=0, S=0, Cout=0, Ovf=0; operand and carry registers cleared. Reset takes effect immediately, including mid-operation; the in-flight operation is discarded with no Done.
- STEPS = WIDTH/DIGIT.
- States: IDLE, RUN.
- IDLE, Start=1 at edge k:
  - latch A.
  - latch B, inverted when Sub=1.
  - carry register = Cin when Sub=0, ~Cin when Sub=1.
  - step count = 0; Busy=1 from edge k.
- RUN, each edge:
  - add the low DIGIT bits of A_reg, B_reg and the carry register.
  - shift the DIGIT sum bits into the top of the internal result shift register, LSB digit first.
  - shift A_reg and B_reg right by DIGIT.
  - carry register = carry out of the slice's MSB.
  - increment the step count.
- Completion at the STEPS-th RUN edge (edge k+STEPS):
  - S <= complete sum.
  - Cout <= final carry.
  - Ovf <= carry into result MSB XOR carry out of result MSB.
  - Done <= 1 for exactly one cycle; Busy <= 0; state = IDLE.
- Latency: Done is high in the cycle starting at edge k+STEPS. Busy is high for exactly STEPS cycles.
- S, Cout and Ovf change only at completion; they hold their values until the next completion or reset. They never show partial sums.
- Start while Busy=1: ignored, with no effect on the operation or on operands.
- Start during the Done cycle: accepted (Busy=0), giving back-to-back operations. Done drops at the next edge, and the new result arrives STEPS cycles later.
- Inputs A, B, Cin and Sub may change freely while Busy=1 without effect.
- Sub=1 arithmetic: S = A + ~B + ~Cin = A - B - Cin (mod 2^WIDTH). Cout=0 indicates a borrow occurred.
- WIDTH=1, DIGIT=1 degenerates to a registered full adder with 1-cycle latency; Ovf = Cin_to_msb XOR Cout.

Test Plan:
- WIDTH=8, DIGIT=1: Start with A=0x0F, B=0x01, Cin=0, Sub=0 -> Busy high 8 cycles; Done pulses at edge k+8; S=0x10, Cout=0, Ovf=0.
- A=0xFF, B=0x01, Cin=0, Sub=0 -> S=0x00, Cout=1, Ovf=0. A=0x7F, B=0x00, Cin=1 -> S=0x80, Cout=0, Ovf=1.
- Sub=1: A=0x05, B=0x07, Cin=0 -> S=0xFE, Cout=0, Ovf=0. A=0x80, B=0x01, Cin=0 -> S=0x7F, Cout=1, Ovf=1.
- WIDTH=8, DIGIT=4: A=0x99, B=0x67, Cin=1 -> Done at edge k+2; S=0x01, Cout=1.
- Start pulsed at edge k+3 of a running operation with different operands -> ignored, result unchanged. Start held during the Done cycle -> second result Done at exactly 8 cycles after it.
- Rst_n pulled low at edge k+4 -> Busy, Done, S, Cout and Ovf go to 0 immediately with no Done pulse. After release, WIDTH=1 exhaustive sweep of all 16 {A,B,Cin,Sub} combinations matches the truth table.
